// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I instruction fetch stage.
// Keeps the fetch PC, issues pipelined word requests to instruction memory,
// buffers returned words with their PCs in a small FIFO and hands one
// {pc, instr} pair per cycle to the decoder under a valid/ready handshake.
// A redirect flushes the buffer and discards every response still in flight.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req / imem_addr     fetch request and word-aligned byte address
//   imem_ready               memory accepts the request this cycle
//   imem_rvalid / imem_rdata in-order response, latency >= 1
//   redirect_valid / _pc     taken branch/jump: flush and refetch
//   id_ready                 decoder accepts the current pair
//   instr_valid              instr_o/pc_o carry a fetched instruction
//   instr_o / pc_o           FIFO head (NOP / 0 when not valid)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      fifo_pc    [FIFO_DEPTH];
  logic [31:0]      fifo_instr [FIFO_DEPTH];

  logic [CNT_W:0]   credits_used;
  logic             issue;
  logic             push;
  logic             pop;
  logic [31:0]      redirect_aligned;

  // Every issued request reserves a FIFO slot until its word is consumed,
  // so outstanding requests plus buffered words never exceed the depth.
  always_comb begin
    credits_used     = {1'b0, inflight} + {1'b0, count};
    imem_req         = !rst && !redirect_valid && (credits_used < DEPTH_LIM);
    imem_addr        = fetch_pc;
    issue            = imem_req && imem_ready;
    push             = imem_rvalid && !redirect_valid && (drop_cnt == '0);
    instr_valid      = (count != '0);
    pop              = instr_valid && id_ready && !redirect_valid;
    instr_o          = instr_valid ? fifo_instr[rd_ptr] : NOP;
    pc_o             = instr_valid ? fifo_pc[rd_ptr] : '0;
    redirect_aligned = redirect_pc & ~32'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      // No issue happens in this cycle; a response arriving now is thrown
      // away, and everything still outstanding afterwards must be dropped.
      fetch_pc <= redirect_aligned;
      resp_pc  <= redirect_aligned;
      inflight <= inflight - CNT_W'(imem_rvalid);
      drop_cnt <= inflight - CNT_W'(imem_rvalid);
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      inflight <= inflight + CNT_W'(issue) - CNT_W'(imem_rvalid);
      if (imem_rvalid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= resp_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  // The credit rule makes a push into a full buffer impossible.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      assert ({1'b0, count} < DEPTH_LIM);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit with an in-order
// instruction memory model of programmable latency and a scoreboard of
// expected {pc, instr} pairs checked whenever the decoder accepts a pair.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q [$];

  logic [31:0] pend_addr [$];
  int unsigned pend_due  [$];
  int unsigned cyc  = 0;
  int unsigned n_hs = 0;
  int unsigned lat  = 1;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .instr_valid   (instr_valid),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  // Releases id_ready again right after the last expected pair is taken.
  task automatic drain(input int unsigned budget);
    int unsigned i;
    i = 0;
    id_ready = 1'b1;
    while (exp_q.size() != 0 && i < budget) begin
      step();
      i++;
    end
    check("drain_done", exp_q.size(), 0);
    id_ready = 1'b0;
  endtask

  // Returns at the start of the first cycle with rst low.
  task automatic do_reset();
    check("phase_drained", exp_q.size(), 0);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    imem_ready     = 1'b1;
    step();
    @(negedge clk);
    check("rst_imem_req", imem_req, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_o", instr_o, 32'h0000_0013);
    check("rst_pc_o", pc_o, 0);
    step();
    rst = 1'b0;
  endtask

  // Memory model: drives responses just after the edge, records handshakes
  // and consumed responses at the falling edge.
  always begin
    @(posedge clk);
    #1;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    @(negedge clk);
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      n_hs = 0;
    end else begin
      if (imem_rvalid) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (imem_req && imem_ready) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + lat);
        n_hs++;
      end
    end
    cyc++;
  end

  // Scoreboard monitor: every accepted pair must match the next expectation.
  always @(negedge clk) begin
    if (!rst && !redirect_valid && instr_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pair: got pc %h, expected no output", pc_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pc_o", pc_o, e.pc);
        check("instr_o", instr_o, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming after reset, latency 1
    lat = 1;
    do_reset();
    id_ready = 1'b1;
    for (int unsigned a = 0; a < 16; a += 4) expect_pc(a);
    @(negedge clk);
    check("p1_first_req", imem_req, 1);
    check("p1_first_addr", imem_addr, 32'h0);
    step();
    @(negedge clk);
    check("p1_not_yet_valid", instr_valid, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("p1_stream_valid", instr_valid, 1);
    end
    step();
    id_ready = 1'b0;

    // Back-pressure fills the buffer and stops issue
    do_reset();
    for (int unsigned a = 0; a < 32; a += 4) expect_pc(a);
    repeat (9) step();
    @(negedge clk);
    check("p2_req_count", n_hs, 4);
    check("p2_req_stopped", imem_req, 0);
    check("p2_head_valid", instr_valid, 1);
    check("p2_head_pc", pc_o, 32'h0);
    step();
    id_ready = 1'b1;
    @(negedge clk);
    check("p2_req_still_low", imem_req, 0);
    step();
    @(negedge clk);
    check("p2_req_back", imem_req, 1);
    step();
    drain(40);

    // Three outstanding requests, none returned yet, then redirect
    lat = 4;
    do_reset();
    id_ready = 1'b1;
    for (int unsigned a = 32'h100; a < 32'h110; a += 4) expect_pc(a);
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check("p3_no_req_in_redirect", imem_req, 0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("p3_req_after_redirect", imem_req, 1);
    check("p3_addr_after_redirect", imem_addr, 32'h100);
    repeat (4) step();
    @(negedge clk);
    check("p3_not_yet_valid", instr_valid, 0);
    step();
    @(negedge clk);
    check("p3_first_valid", instr_valid, 1);
    step();
    drain(40);

    // Redirect coinciding with a response, latency 3
    lat = 3;
    do_reset();
    id_ready = 1'b1;
    expect_pc(32'h200);
    expect_pc(32'h204);
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    check("p4_no_req_in_redirect", imem_req, 0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("p4_addr_after_redirect", imem_addr, 32'h200);
    repeat (3) step();
    @(negedge clk);
    check("p4_not_yet_valid", instr_valid, 0);
    step();
    @(negedge clk);
    check("p4_first_valid", instr_valid, 1);
    step();
    drain(40);

    // Memory stall keeps the address stable
    lat = 1;
    do_reset();
    id_ready = 1'b1;
    for (int unsigned a = 0; a < 16; a += 4) expect_pc(a);
    @(negedge clk);
    check("p5_first_addr", imem_addr, 32'h0);
    step();
    imem_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      check("p5_stall_req", imem_req, 1);
      check("p5_stall_addr", imem_addr, 32'h4);
      step();
    end
    imem_ready = 1'b1;
    @(negedge clk);
    check("p5_resume_addr", imem_addr, 32'h4);
    step();
    drain(40);

    // PC wrap, misaligned redirect, reset mid-stream
    do_reset();
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    @(negedge clk);
    check("p6_no_req_in_redirect", imem_req, 0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("p6_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    check("p6_addr_wrap", imem_addr, 32'h0);
    step();
    drain(40);
    expect_pc(32'h100);
    expect_pc(32'h104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    @(negedge clk);
    check("p6_no_req_misaligned", imem_req, 0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("p6_req_aligned", imem_req, 1);
    check("p6_addr_aligned", imem_addr, 32'h100);
    step();
    drain(40);
    repeat (6) step();
    @(negedge clk);
    check("p6_buffer_filled", instr_valid, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("p6_req_in_rst", imem_req, 0);
    step();
    @(negedge clk);
    check("p6_rst_valid", instr_valid, 0);
    check("p6_rst_instr", instr_o, 32'h0000_0013);
    check("p6_rst_pc", pc_o, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("p6_post_rst_req", imem_req, 1);
    check("p6_post_rst_addr", imem_addr, 32'h0);
    check("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
